visualizer_write_scheduler: RTL and testbench

Write-port controller for the visualizer's bar-height RAM (SCREEN_HEIGHT x 32-bit). It arbitrates update requests from several producers, buffers them in a small FIFO, and drives the visualizer's `tg_write_en`/`tg_addr`/`tg_input` port only during vertical blanking. Restricting writes to blanking stops a write from stealing the shared RAM address during active-video reads. It also runs a full-table clear sweep on command.

---
 rtl/visualizer_write_scheduler.sv | 165 ++++++++++++++++
 tb/tb_visualizer_write_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/visualizer_write_scheduler.sv
// Write-port scheduler for the visualizer bar-height RAM: round-robin request intake,
// a small FIFO, and a blanking-only write path with a full-table clear sweep.
module visualizer_write_scheduler #(
  parameter int SCREEN_HEIGHT = 42,
  parameter int NUM_REQ       = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int V_TOTAL       = 750
) (
  input  logic                     pixel_clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ-1:0][5:0]  req_addr_in,
  input  logic [NUM_REQ-1:0][31:0] req_data_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic                     clear_in,
  output logic                     tg_write_en_out,
  output logic [5:0]               tg_addr_out,
  output logic [31:0]              tg_input_out,
  output logic                     busy_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] WIN_START = 10'(16 * SCREEN_HEIGHT);
  localparam logic [9:0] WIN_END = 10'(V_TOTAL - 1);
  localparam logic [5:0] LAST_ADDR = 6'(SCREEN_HEIGHT - 1);
  localparam logic [6:0] ADDR_LIMIT = 7'(SCREEN_HEIGHT);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [RW-1:0] RR_LAST = RW'(NUM_REQ - 1);
  localparam logic [RW-1:0] RR_ONE = RW'(1);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  state_t          state, state_next;
  logic [37:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [RW-1:0]   rr_ptr, sel, cand;
  logic            found, accept, push, pop, sweep_step;
  logic            win, fifo_empty, fifo_full, clear_pending;
  logic [5:0]      clr_addr;
  logic            unused;

  assign unused     = ^hcount_in;
  assign win        = (vcount_in >= WIN_START) && (vcount_in < WIN_END);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy_out   = clear_pending | !fifo_empty;

  // Round-robin search starting at rr_ptr; grant only when the FIFO has room.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = RW'((int'(rr_ptr) + off) % NUM_REQ);
      if (!found && req_valid_in[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    accept        = found && !fifo_full && rst_in;
    req_ready_out = '0;
    if (accept) begin
      req_ready_out[sel] = 1'b1;
    end
    // Out-of-range addresses complete the handshake but are dropped here.
    push = accept && ({1'b0, req_addr_in[sel]} < ADDR_LIMIT);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    sweep_step = 1'b0;
    case (state)
      IDLE: begin
        if (win && clear_pending) begin
          state_next = CLEAR;
        end else if (win && !fifo_empty && !clear_in) begin
          state_next = DRAIN;
        end
      end
      CLEAR: begin
        if (!win) begin
          state_next = IDLE;
        end else begin
          sweep_step = 1'b1;
          if (clr_addr == LAST_ADDR && !clear_in) begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        // A pending clear must take precedence over anything still queued.
        if (!win || clear_in || clear_pending || fifo_empty) begin
          state_next = IDLE;
        end else begin
          pop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {req_addr_in[sel], req_data_in[sel]};
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rr_ptr          <= '0;
      clear_pending   <= 1'b0;
      clr_addr        <= '0;
      tg_write_en_out <= 1'b0;
      tg_addr_out     <= '0;
      tg_input_out    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // Flushing moves the read pointer to the pre-push write pointer,
      // so a request accepted alongside the clear survives.
      if (clear_in) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept) begin
        rr_ptr <= (sel == RR_LAST) ? '0 : sel + RR_ONE;
      end
      if (clear_in) begin
        clear_pending <= 1'b1;
        clr_addr      <= '0;
      end else if (sweep_step) begin
        if (clr_addr == LAST_ADDR) begin
          clear_pending <= 1'b0;
          clr_addr      <= '0;
        end else begin
          clr_addr <= clr_addr + 6'd1;
        end
      end
      tg_write_en_out <= pop | sweep_step;
      if (sweep_step) begin
        tg_addr_out  <= clr_addr;
        tg_input_out <= '0;
      end else if (pop) begin
        {tg_addr_out, tg_input_out} <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_visualizer_write_scheduler.sv
// Directed bench for visualizer_write_scheduler: each task drives one scenario and
// checks the write strobes logged by a negedge monitor against hand-derived values.
module tb_visualizer_write_scheduler;

  logic              pixel_clk_in = 1'b0;
  logic              rst_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [1:0]        req_valid;
  logic [1:0][5:0]   req_addr;
  logic [1:0][31:0]  req_data;
  logic [1:0]        req_ready;
  logic              clear_in;
  logic              tg_write_en;
  logic [5:0]        tg_addr;
  logic [31:0]       tg_input;
  logic              busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int p0_idx = 0;
  logic [9:0] last_v = '0;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [9:0]  wv_q[$];
  logic [9:0]  wp_q[$];
  int          wc_q[$];

  always #5 pixel_clk_in = ~pixel_clk_in;

  visualizer_write_scheduler dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .req_valid_in   (req_valid),
    .req_addr_in    (req_addr),
    .req_data_in    (req_data),
    .req_ready_out  (req_ready),
    .clear_in       (clear_in),
    .tg_write_en_out(tg_write_en),
    .tg_addr_out    (tg_addr),
    .tg_input_out   (tg_input),
    .busy_out       (busy)
  );

  // Logs every write strobe with its vcount and the vcount of the deciding cycle.
  always @(negedge pixel_clk_in) begin
    cyc = cyc + 1;
    if (tg_write_en === 1'b1) begin
      wa_q.push_back(tg_addr);
      wd_q.push_back(tg_input);
      wv_q.push_back(vcount_in);
      wp_q.push_back(last_v);
      wc_q.push_back(cyc);
      $display("write addr=%0d data=0x%0h vcount=%0d", tg_addr, tg_input, vcount_in);
    end
    last_v = vcount_in;
  end

  task automatic tick();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wv_q.delete();
    wp_q.delete();
    wc_q.delete();
  endtask

  task automatic do_reset();
    rst_in    = 1'b0;
    req_valid = '0;
    clear_in  = 1'b0;
    vcount_in = 10'd100;
    tick();
    tick();
    rst_in = 1'b1;
    clear_log();
  endtask

  // Requester 0 offers items p0_idx..9 (addr = index, data = 0x300 + index).
  task automatic p0_cycle(input logic [9:0] v);
    logic took;
    vcount_in    = v;
    req_valid[0] = (p0_idx < 10);
    req_addr[0]  = 6'(p0_idx);
    req_data[0]  = 32'h300 + 32'(p0_idx);
    #1;
    took = req_ready[0] && req_valid[0];
    tick();
    if (took) p0_idx++;
  endtask

  task automatic test_reset();
    rst_in      = 1'b0;
    req_valid   = 2'b11;
    req_addr[0] = 6'd1;
    req_addr[1] = 6'd2;
    req_data[0] = 32'h11;
    req_data[1] = 32'h22;
    clear_in    = 1'b0;
    vcount_in   = 10'd700;
    tick();
    tick();
    n_checks++; if (tg_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0h expected 0", tg_write_en); end
    n_checks++; if (tg_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", tg_addr); end
    n_checks++; if (tg_input !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", tg_input); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %0h expected 0", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    logic [9:0] vlist [3];
    vlist = '{10'd100, 10'd300, 10'd671};
    do_reset();
    req_valid[0] = 1'b1;
    req_addr[0]  = 6'd5;
    req_data[0]  = 32'd3;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %0h expected 1", req_ready); end
    tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      vcount_in = vlist[i];
      repeat (5) tick();
    end
    n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL single_early_strobe: got %0d expected 0", wa_q.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %0h expected 1", busy); end
    vcount_in = 10'd672;
    tick();
    tick();
    n_checks++; if (tg_write_en !== 1'b1) begin n_fail++; $display("FAIL single_latency_en: got %0h expected 1", tg_write_en); end
    n_checks++; if (tg_addr !== 6'd5) begin n_fail++; $display("FAIL single_addr: got %0d expected 5", tg_addr); end
    n_checks++; if (tg_input !== 32'd3) begin n_fail++; $display("FAIL single_data: got %0h expected 3", tg_input); end
    tick();
    n_checks++; if (tg_write_en !== 1'b0) begin n_fail++; $display("FAIL single_one_strobe: got %0h expected 0", tg_write_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %0h expected 0", busy); end
    repeat (3) tick();
    n_checks++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", wa_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [5:0]  ea[$];
    logic [31:0] ed[$];
    logic [1:0]  exp_ready;
    int idx0, idx1, acc, turn;
    idx0 = 0; idx1 = 0; acc = 0; turn = 0;
    do_reset();
    vcount_in = 10'd100;
    for (int c = 0; c < 10; c++) begin
      req_valid[0] = (idx0 < 6);
      req_valid[1] = (idx1 < 6);
      req_addr[0]  = 6'(10 + idx0);
      req_data[0]  = 32'h100 + 32'(idx0);
      req_addr[1]  = 6'(20 + idx1);
      req_data[1]  = 32'h200 + 32'(idx1);
      #1;
      exp_ready = (acc < 8) ? ((turn == 0) ? 2'b01 : 2'b10) : 2'b00;
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_grant cycle %0d: got %0b expected %0b", c, req_ready, exp_ready); end
      if (acc < 8) begin
        if (turn == 0) begin
          ea.push_back(6'(10 + idx0)); ed.push_back(32'h100 + 32'(idx0)); idx0++;
        end else begin
          ea.push_back(6'(20 + idx1)); ed.push_back(32'h200 + 32'(idx1)); idx1++;
        end
        turn = 1 - turn;
        acc++;
      end
      tick();
    end
    req_valid = '0;
    vcount_in = 10'd700;
    repeat (15) tick();
    n_checks++; if (wa_q.size() !== 8) begin n_fail++; $display("FAIL rr_write_count: got %0d expected 8", wa_q.size()); end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      n_checks++;
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL rr_order %0d: got addr %0d data %0h expected addr %0d data %0h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_window_edge();
    logic [9:0] seq [13];
    int first_frame;
    int bad_v;
    seq = '{10'd745, 10'd746, 10'd747, 10'd748, 10'd749, 10'd0, 10'd0, 10'd0,
            10'd100, 10'd100, 10'd100, 10'd100, 10'd100};
    do_reset();
    p0_idx = 0;
    for (int i = 0; i < 10; i++) p0_cycle(10'd100);
    n_checks++; if (p0_idx !== 8) begin n_fail++; $display("FAIL edge_fill: got %0d expected 8", p0_idx); end
    for (int i = 0; i < 13; i++) p0_cycle(seq[i]);
    req_valid = '0;
    first_frame = wa_q.size();
    n_checks++; if (first_frame !== 3) begin n_fail++; $display("FAIL edge_first_frame: got %0d expected 3", first_frame); end
    n_checks++; if (p0_idx !== 10) begin n_fail++; $display("FAIL edge_all_accepted: got %0d expected 10", p0_idx); end
    vcount_in = 10'd672;
    repeat (12) tick();
    n_checks++; if (wa_q.size() !== 10) begin n_fail++; $display("FAIL edge_total: got %0d expected 10", wa_q.size()); end
    bad_v = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wv_q[i] == 10'd0 || wp_q[i] < 10'd672 || wp_q[i] > 10'd748) bad_v++;
      n_checks++;
      if (i < 10 && (wa_q[i] !== 6'(i) || wd_q[i] !== 32'h300 + 32'(i))) begin
        n_fail++;
        $display("FAIL edge_order %0d: got addr %0d data %0h expected addr %0d data %0h", i, wa_q[i], wd_q[i], i, 32'h300 + 32'(i));
      end
    end
    n_checks++; if (bad_v !== 0) begin n_fail++; $display("FAIL edge_outside_window: got %0d strobes expected 0", bad_v); end
  endtask

  task automatic test_clear();
    do_reset();
    vcount_in = 10'd100;
    for (int i = 0; i < 3; i++) begin
      req_valid    = 2'b01;
      req_addr[0]  = 6'(1 + i);
      req_data[0]  = 32'h40 + 32'(i);
      tick();
    end
    req_valid    = 2'b10;
    req_addr[1]  = 6'd7;
    req_data[1]  = 32'h77;
    clear_in     = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL clear_same_cycle_ready: got %0b expected 10", req_ready); end
    tick();
    clear_in  = 1'b0;
    req_valid = '0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy: got %0h expected 1", busy); end
    vcount_in = 10'd700;
    repeat (60) tick();
    n_checks++; if (wa_q.size() !== 43) begin n_fail++; $display("FAIL clear_count: got %0d expected 43", wa_q.size()); end
    for (int i = 0; i < 42 && i < wa_q.size(); i++) begin
      n_checks++;
      if (wa_q[i] !== 6'(i) || wd_q[i] !== 32'd0 || wc_q[i] !== wc_q[0] + i) begin
        n_fail++;
        $display("FAIL clear_sweep %0d: got addr %0d data %0h cycle +%0d expected addr %0d data 0 cycle +%0d", i, wa_q[i], wd_q[i], wc_q[i] - wc_q[0], i, i);
      end
    end
    if (wa_q.size() > 42) begin
      n_checks++;
      if (wa_q[42] !== 6'd7 || wd_q[42] !== 32'h77) begin
        n_fail++;
        $display("FAIL clear_retained: got addr %0d data %0h expected addr 7 data 77", wa_q[42], wd_q[42]);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_busy: got %0h expected 0", busy); end
  endtask

  task automatic test_clear_split();
    int first_frame;
    do_reset();
    vcount_in = 10'd100;
    clear_in  = 1'b1;
    tick();
    clear_in  = 1'b0;
    vcount_in = 10'd728;
    tick();
    for (int v = 729; v <= 748; v++) begin
      vcount_in = 10'(v);
      tick();
    end
    vcount_in = 10'd749;
    tick();
    vcount_in = 10'd0;
    repeat (3) tick();
    first_frame = wa_q.size();
    n_checks++; if (first_frame !== 20) begin n_fail++; $display("FAIL split_first_frame: got %0d expected 20", first_frame); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL split_pending: got %0h expected 1", busy); end
    vcount_in = 10'd672;
    repeat (30) tick();
    n_checks++; if (wa_q.size() !== 42) begin n_fail++; $display("FAIL split_total: got %0d expected 42", wa_q.size()); end
    for (int i = 0; i < 42 && i < wa_q.size(); i++) begin
      n_checks++;
      if (wa_q[i] !== 6'(i) || wd_q[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL split_addr %0d: got addr %0d data %0h expected addr %0d data 0", i, wa_q[i], wd_q[i], i);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL split_busy_end: got %0h expected 0", busy); end
  endtask

  task automatic test_discard_reset();
    do_reset();
    vcount_in    = 10'd100;
    req_valid    = 2'b01;
    req_addr[0]  = 6'd42;
    req_data[0]  = 32'h99;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL discard_ready: got %0b expected 01", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL discard_busy: got %0h expected 0", busy); end
    vcount_in = 10'd700;
    repeat (6) tick();
    n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL discard_strobe: got %0d expected 0", wa_q.size()); end
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    repeat (9) tick();
    n_checks++; if (tg_write_en !== 1'b1 || tg_addr !== 6'd7) begin n_fail++; $display("FAIL midsweep: got en %0h addr %0d expected en 1 addr 7", tg_write_en, tg_addr); end
    rst_in       = 1'b0;
    req_valid    = 2'b01;
    req_addr[0]  = 6'd3;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready_low: got %0b expected 00", req_ready); end
    tick();
    n_checks++; if (tg_write_en !== 1'b0) begin n_fail++; $display("FAIL midreset_en: got %0h expected 0", tg_write_en); end
    n_checks++; if (tg_addr !== 6'd0) begin n_fail++; $display("FAIL midreset_addr: got %0d expected 0", tg_addr); end
    n_checks++; if (tg_input !== 32'd0) begin n_fail++; $display("FAIL midreset_data: got %0h expected 0", tg_input); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0h expected 0", busy); end
    rst_in    = 1'b1;
    req_valid = '0;
    clear_log();
    repeat (8) tick();
    n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL post_reset_strobe: got %0d expected 0", wa_q.size()); end
  endtask

  initial begin
    rst_in    = 1'b0;
    hcount_in = '0;
    vcount_in = '0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clear_in  = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_window_edge();
    test_clear();
    test_clear_split();
    test_discard_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
